// File: rtl/step_trace_scheduler.sv
// ============================================================================
// Module   : step_trace_scheduler
// Purpose  : Ping-pong capture of stepper coil phases, rendered as four
//            logic-analyser traces into a DE/HSYNC/VSYNC pixel stream.
// Revision : 1.0
// ============================================================================
`default_nettype none

module step_trace_scheduler #(
    parameter int          DEPTH    = 256,
    parameter int          XSHIFT   = 2,
    parameter int          LANE_TOP = 100,
    parameter int          LANE_H   = 32,
    parameter int          LANE_GAP = 16,
    parameter logic [23:0] FG       = 24'h000000,
    parameter logic [23:0] BG       = 24'heeeeee
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        capture_en,
    input  logic [3:0]  phase,
    input  logic        sample_tick,
    input  logic        in_de,
    input  logic        in_hsync,
    input  logic        in_vsync,
    output logic [23:0] video_data,
    output logic        video_de,
    output logic        video_hsync,
    output logic        video_vsync,
    output logic        capture_busy,
    output logic        frame_valid
);

    localparam int AW      = $clog2(DEPTH);
    localparam int TRACE_W = DEPTH << XSHIFT;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t          state, state_nx;
    logic            cap_bank, cap_bank_nx;
    logic            disp_bank, disp_bank_nx;
    logic            frame_valid_nx;
    logic [AW-1:0]   wr_addr, wr_addr_nx;
    logic            wr_en;
    logic [AW:0]     wr_ptr;

    logic            phase0_prev;
    logic            vsync_prev;
    logic            de_prev;
    logic            phase_rise;
    logic            vsync_rise;

    logic [10:0]     x, y;

    logic [3:0]      mem [0:2*DEPTH-1];
    logic [3:0]      rd_data;
    logic [3:0]      rd_prev;
    logic [AW-1:0]   rd_idx;

    logic            de_s1, hs_s1, vs_s1, fv_s1;
    logic            in_range_s1, edge_col_s1, first_s1;
    logic [3:0]      top_hit_s1, bot_hit_s1, in_lane_s1;
    logic [3:0]      top_hit, bot_hit, in_lane;

    logic [3:0]      prev_samp;
    logic [3:0]      lane_fg;
    logic            pixel_fg;

    assign phase_rise   = phase[0] & ~phase0_prev;
    assign vsync_rise   = in_vsync & ~vsync_prev;
    assign capture_busy = (state == ST_ARMED) || (state == ST_CAPTURE);

    // ------------------------------------------------------------------
    // Capture sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_nx       = state;
        cap_bank_nx    = cap_bank;
        disp_bank_nx   = disp_bank;
        frame_valid_nx = frame_valid;
        wr_addr_nx     = wr_addr;
        wr_en          = 1'b0;
        wr_ptr         = {cap_bank, wr_addr};

        if (!capture_en) begin
            state_nx   = ST_IDLE;
            wr_addr_nx = '0;
        end else begin
            case (state)
                ST_IDLE: state_nx = ST_ARMED;
                ST_ARMED: begin
                    // Trigger sample lands in slot 0; a coincident tick is not a second write.
                    if (phase_rise) begin
                        wr_en      = 1'b1;
                        wr_ptr     = {cap_bank, {AW{1'b0}}};
                        wr_addr_nx = AW'(1);
                        state_nx   = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (sample_tick) begin
                        wr_en      = 1'b1;
                        wr_addr_nx = wr_addr + AW'(1);
                        if (wr_addr == AW'(DEPTH - 1)) begin
                            state_nx = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (vsync_rise) begin
                        cap_bank_nx    = disp_bank;
                        disp_bank_nx   = cap_bank;
                        frame_valid_nx = 1'b1;
                        wr_addr_nx     = '0;
                        state_nx       = ST_ARMED;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cap_bank    <= 1'b0;
            disp_bank   <= 1'b1;
            frame_valid <= 1'b0;
            wr_addr     <= '0;
            phase0_prev <= 1'b0;
            vsync_prev  <= 1'b0;
            de_prev     <= 1'b0;
            x           <= '0;
            y           <= '0;
        end else begin
            state       <= state_nx;
            cap_bank    <= cap_bank_nx;
            disp_bank   <= disp_bank_nx;
            frame_valid <= frame_valid_nx;
            wr_addr     <= wr_addr_nx;
            phase0_prev <= phase[0];
            vsync_prev  <= in_vsync;
            de_prev     <= in_de;

            if (!in_de) begin
                x <= '0;
            end else if (x != 11'h7ff) begin
                x <= x + 11'd1;
            end

            if (vsync_rise) begin
                y <= '0;
            end else if (de_prev && !in_de && (y != 11'h7ff)) begin
                y <= y + 11'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sample buffer: kept reset-free so it maps onto block RAM
    // ------------------------------------------------------------------
    assign rd_idx = AW'(x >> XSHIFT);

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= phase;
        end
        rd_data <= mem[{disp_bank, rd_idx}];
        rd_prev <= rd_data;
    end

    // ------------------------------------------------------------------
    // Render stage 1: row decode per lane
    // ------------------------------------------------------------------
    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_lane
            localparam int TOP = LANE_TOP + k * (LANE_H + LANE_GAP);
            localparam int BOT = TOP + LANE_H - 1;
            assign top_hit[k] = (y == 11'(TOP));
            assign bot_hit[k] = (y == 11'(BOT));
            assign in_lane[k] = (y >= 11'(TOP)) && (y <= 11'(BOT));
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            de_s1       <= 1'b0;
            hs_s1       <= 1'b0;
            vs_s1       <= 1'b0;
            fv_s1       <= 1'b0;
            in_range_s1 <= 1'b0;
            edge_col_s1 <= 1'b0;
            first_s1    <= 1'b0;
            top_hit_s1  <= '0;
            bot_hit_s1  <= '0;
            in_lane_s1  <= '0;
            video_de    <= 1'b0;
            video_hsync <= 1'b0;
            video_vsync <= 1'b0;
            video_data  <= '0;
        end else begin
            de_s1       <= in_de;
            hs_s1       <= in_hsync;
            vs_s1       <= in_vsync;
            fv_s1       <= frame_valid;
            in_range_s1 <= int'(x) < TRACE_W;
            edge_col_s1 <= (x & 11'((1 << XSHIFT) - 1)) == 11'd0;
            first_s1    <= (x >> XSHIFT) == 11'd0;
            top_hit_s1  <= top_hit;
            bot_hit_s1  <= bot_hit;
            in_lane_s1  <= in_lane;

            video_de    <= de_s1;
            video_hsync <= hs_s1;
            video_vsync <= vs_s1;
            video_data  <= !de_s1 ? 24'd0 : (pixel_fg ? FG : BG);
        end
    end

    // ------------------------------------------------------------------
    // Render stage 2: rd_prev holds sample i-1 because x walks contiguously
    // ------------------------------------------------------------------
    assign prev_samp = first_s1 ? rd_data : rd_prev;
    assign lane_fg   = (rd_data & top_hit_s1)
                     | (~rd_data & bot_hit_s1)
                     | ((rd_data ^ prev_samp) & in_lane_s1 & {4{edge_col_s1}});
    assign pixel_fg  = fv_s1 & in_range_s1 & (|lane_fg);

endmodule

`default_nettype wire

// File: tb/tb_step_trace_scheduler.sv
// ============================================================================
// Module   : tb_step_trace_scheduler
// Purpose  : Directed scenario bench for step_trace_scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_step_trace_scheduler;

    localparam logic [23:0] FGC = 24'h000000;
    localparam logic [23:0] BGC = 24'heeeeee;
    localparam int          FULL = 1030;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        capture_en = 1'b0;
    logic [3:0]  phase = 4'd0;
    logic        sample_tick = 1'b0;
    logic        in_de = 1'b0;
    logic        in_hsync = 1'b0;
    logic        in_vsync = 1'b0;
    logic [23:0] video_data;
    logic        video_de;
    logic        video_hsync;
    logic        video_vsync;
    logic        capture_busy;
    logic        frame_valid;

    int          total = 0;
    int          bad = 0;
    logic [23:0] line_buf [0:2047];
    int          pix;
    int          zero_viol = 0;
    int          cur_row = 0;
    int          first_bad;
    logic [23:0] fb_act, fb_exp;

    always #5 clock = ~clock;

    step_trace_scheduler dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .capture_en   (capture_en),
        .phase        (phase),
        .sample_tick  (sample_tick),
        .in_de        (in_de),
        .in_hsync     (in_hsync),
        .in_vsync     (in_vsync),
        .video_data   (video_data),
        .video_de     (video_de),
        .video_hsync  (video_hsync),
        .video_vsync  (video_vsync),
        .capture_busy (capture_busy),
        .frame_valid  (frame_valid)
    );

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] samp(input int mode, input int j);
        logic [31:0] jv;
        jv = j;
        case (mode)
            0:       return 4'b0001;
            1:       return {1'b0, jv[0], 2'b01};
            default: return 4'b0011;
        endcase
    endfunction

    function automatic logic [23:0] exp_pix(input int mode, input bit valid, input int row, input int x);
        logic [3:0] sv, pv;
        int top, i;
        if (!valid || x >= 1024) return BGC;
        i  = x / 4;
        sv = samp(mode, i);
        pv = (i == 0) ? sv : samp(mode, i - 1);
        for (int k = 0; k < 4; k++) begin
            top = 100 + k * 48;
            if (row >= top && row <= top + 31) begin
                if ((sv[k] && row == top) || (!sv[k] && row == top + 31) ||
                    (sv[k] != pv[k] && (x % 4) == 0))
                    return FGC;
                return BGC;
            end
        end
        return BGC;
    endfunction

    // Advance to the next negedge, record the pixel leaving the DUT, then drive video inputs.
    task automatic cycle(input logic de, input logic hs, input logic vs);
        @(negedge clock);
        if (video_de) begin
            if (pix < 2048) line_buf[pix] = video_data;
            pix++;
        end else if (video_data !== 24'd0) begin
            zero_viol++;
        end
        in_de = de; in_hsync = hs; in_vsync = vs;
    endtask

    task automatic do_line(input int len);
        if (len > 1) begin
            cycle(0, 0, 0);
            cycle(0, 0, 0);
        end
        pix = 0;
        for (int i = 0; i < len; i++) cycle(1, 0, 0);
        for (int i = 0; i < ((len > 1) ? 4 : 1); i++) cycle(0, 0, 0);
        cur_row++;
    endtask

    task automatic goto_row(input int r);
        while (cur_row < r) do_line(1);
    endtask

    task automatic vsync_pulse();
        cycle(0, 0, 1);
        cycle(0, 0, 0);
        cur_row = 0;
    endtask

    task automatic run_capture(input int mode, input int nticks);
        capture_en = 1'b1; phase = 4'd0; sample_tick = 1'b0;
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        phase = samp(mode, 0);
        cycle(0, 0, 0);
        for (int j = 1; j <= nticks; j++) begin
            phase = samp(mode, j); sample_tick = 1'b1;
            cycle(0, 0, 0);
        end
        sample_tick = 1'b0;
    endtask

    // Renders row r as a full line and locates the first pixel off the reference.
    task automatic scan_row(input int mode, input bit valid, input int r);
        goto_row(r);
        do_line(FULL);
        first_bad = -1;
        for (int xx = FULL - 1; xx >= 0; xx--) begin
            if (line_buf[xx] !== exp_pix(mode, valid, r, xx)) begin
                first_bad = xx; fb_act = line_buf[xx]; fb_exp = exp_pix(mode, valid, r, xx);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        cycle(0, 0, 0);
        total++;
        if ({video_data, video_de, video_hsync, video_vsync, capture_busy, frame_valid} !== 29'd0) begin
            bad++; $display("FAIL reset_outputs: got %h want 0",
                {video_data, video_de, video_hsync, video_vsync, capture_busy, frame_valid});
        end
        vsync_pulse();
        scan_row(0, 0, 100);
        total++;
        if (first_bad >= 0) begin
            bad++; $display("FAIL novalid_row100: x=%0d got %h want %h", first_bad, fb_act, fb_exp);
        end
        run_capture(0, 99);
        total++;
        if (capture_busy !== 1'b1) begin
            bad++; $display("FAIL busy_mid_capture: got %b want 1", capture_busy);
        end
        cycle(1, 1, 0); cycle(1, 1, 0); cycle(1, 1, 0);
        total++;
        if (video_de !== 1'b1) begin
            bad++; $display("FAIL de_before_reset: got %b want 1", video_de);
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({video_data, video_de, video_hsync, video_vsync, capture_busy, frame_valid} !== 29'd0) begin
            bad++; $display("FAIL async_reset_outputs: got %h want 0",
                {video_data, video_de, video_hsync, video_vsync, capture_busy, frame_valid});
        end
        @(negedge clock);
        in_de = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0;
        capture_en = 1'b0; sample_tick = 1'b0; phase = 4'd0;
        reset_n = 1'b1;
        cycle(0, 0, 0);
        total++;
        if ({capture_busy, frame_valid} !== 2'b00) begin
            bad++; $display("FAIL post_reset_idle: got %b want 00", {capture_busy, frame_valid});
        end
    endtask

    task automatic test_capture();
        run_capture(0, 254);
        total++;
        if ({capture_busy, frame_valid} !== 2'b10) begin
            bad++; $display("FAIL before_last_tick: got %b want 10", {capture_busy, frame_valid});
        end
        phase = samp(0, 255); sample_tick = 1'b1;
        cycle(0, 0, 0);
        sample_tick = 1'b0;
        repeat (5) cycle(0, 0, 0);
        total++;
        if ({capture_busy, frame_valid} !== 2'b00) begin
            bad++; $display("FAIL done_waiting: got %b want 00", {capture_busy, frame_valid});
        end
        vsync_pulse();
        total++;
        if ({capture_busy, frame_valid} !== 2'b11) begin
            bad++; $display("FAIL swap_at_vsync: got %b want 11", {capture_busy, frame_valid});
        end
    endtask

    task automatic test_display();
        scan_row(0, 1, 100);
        total++;
        if (first_bad >= 0) begin
            bad++; $display("FAIL row100: x=%0d got %h want %h", first_bad, fb_act, fb_exp);
        end
        total++;
        if ({line_buf[0], line_buf[1023], line_buf[1024]} !== {FGC, FGC, BGC}) begin
            bad++; $display("FAIL row100_spots: got %h %h %h want %h %h %h",
                line_buf[0], line_buf[1023], line_buf[1024], FGC, FGC, BGC);
        end
        total++;
        if (pix !== FULL) begin
            bad++; $display("FAIL line_len: got %0d want %0d", pix, FULL);
        end
        scan_row(0, 1, 131);
        total++;
        if (first_bad >= 0 || line_buf[500] !== BGC) begin
            bad++; $display("FAIL row131: x=%0d got %h want %h", first_bad, fb_act, fb_exp);
        end
        scan_row(0, 1, 179);
        total++;
        if (first_bad >= 0 || line_buf[0] !== FGC) begin
            bad++; $display("FAIL row179: x=%0d got %h want %h", first_bad, fb_act, fb_exp);
        end
        total++;
        if (zero_viol !== 0) begin
            bad++; $display("FAIL blank_data: got %0d nonzero want 0", zero_viol);
        end
    endtask

    task automatic test_delay();
        logic [15:0] pd, ph, pv;
        pd = 16'b0011_1101_1001_0110;
        ph = 16'b1100_0110_0011_1000;
        pv = 16'b0000_1110_0100_1100;
        for (int i = 0; i < 16; i++) begin
            cycle(pd[i], ph[i], pv[i]);
            if (i >= 2) begin
                total++;
                if ({video_de, video_hsync, video_vsync} !== {pd[i-2], ph[i-2], pv[i-2]}) begin
                    bad++; $display("FAIL delay2_%0d: got %b want %b", i,
                        {video_de, video_hsync, video_vsync}, {pd[i-2], ph[i-2], pv[i-2]});
                end
            end
        end
        cycle(0, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0);
    endtask

    task automatic test_transitions();
        run_capture(1, 255);
        vsync_pulse();
        scan_row(1, 1, 195);
        total++;
        if (first_bad >= 0) begin
            bad++; $display("FAIL row195: x=%0d got %h want %h", first_bad, fb_act, fb_exp);
        end
        scan_row(1, 1, 196);
        total++;
        if (first_bad >= 0 || {line_buf[0], line_buf[4]} !== {BGC, FGC}) begin
            bad++; $display("FAIL row196: x=%0d got %h want %h", first_bad, fb_act, fb_exp);
        end
        scan_row(1, 1, 200);
        total++;
        if (first_bad >= 0) begin
            bad++; $display("FAIL row200: x=%0d got %h want %h", first_bad, fb_act, fb_exp);
        end
        total++;
        if ({line_buf[0], line_buf[4], line_buf[5], line_buf[1020], line_buf[1024]} !==
            {BGC, FGC, BGC, FGC, BGC}) begin
            bad++; $display("FAIL row200_spots: got %h %h %h %h %h", line_buf[0], line_buf[4],
                line_buf[5], line_buf[1020], line_buf[1024]);
        end
        scan_row(1, 1, 227);
        total++;
        if (first_bad >= 0) begin
            bad++; $display("FAIL row227: x=%0d got %h want %h", first_bad, fb_act, fb_exp);
        end
        scan_row(1, 1, 228);
        total++;
        if (first_bad >= 0) begin
            bad++; $display("FAIL row228: x=%0d got %h want %h", first_bad, fb_act, fb_exp);
        end
    endtask

    task automatic test_abort();
        run_capture(2, 49);
        total++;
        if (capture_busy !== 1'b1) begin
            bad++; $display("FAIL busy_at_50: got %b want 1", capture_busy);
        end
        capture_en = 1'b0;
        cycle(0, 0, 0);
        total++;
        if ({capture_busy, frame_valid} !== 2'b01) begin
            bad++; $display("FAIL abort_idle: got %b want 01", {capture_busy, frame_valid});
        end
        for (int f = 0; f < 2; f++) begin
            vsync_pulse();
            scan_row(1, 1, 148);
            total++;
            if (first_bad >= 0 || line_buf[0] !== BGC) begin
                bad++; $display("FAIL abort_row148_f%0d: x=%0d got %h want %h", f, first_bad, fb_act, fb_exp);
            end
            scan_row(1, 1, 200);
            total++;
            if (first_bad >= 0 || line_buf[4] !== FGC) begin
                bad++; $display("FAIL abort_row200_f%0d: x=%0d got %h want %h", f, first_bad, fb_act, fb_exp);
            end
        end
        total++;
        if (frame_valid !== 1'b1) begin
            bad++; $display("FAIL abort_valid: got %b want 1", frame_valid);
        end
    endtask

    task automatic test_midframe();
        vsync_pulse();
        goto_row(140);
        run_capture(2, 255);
        total++;
        if ({capture_busy, frame_valid} !== 2'b01) begin
            bad++; $display("FAIL mid_done: got %b want 01", {capture_busy, frame_valid});
        end
        scan_row(1, 1, 148);
        total++;
        if (first_bad >= 0 || line_buf[0] !== BGC) begin
            bad++; $display("FAIL mid_row148_old: x=%0d got %h want %h", first_bad, fb_act, fb_exp);
        end
        scan_row(1, 1, 200);
        total++;
        if (first_bad >= 0 || line_buf[4] !== FGC) begin
            bad++; $display("FAIL mid_row200_old: x=%0d got %h want %h", first_bad, fb_act, fb_exp);
        end
        scan_row(1, 1, 300);
        total++;
        if (first_bad >= 0 || capture_busy !== 1'b0) begin
            bad++; $display("FAIL mid_row300: x=%0d got %h want %h busy=%b", first_bad, fb_act, fb_exp, capture_busy);
        end
        vsync_pulse();
        total++;
        if (capture_busy !== 1'b1) begin
            bad++; $display("FAIL mid_swap_armed: got %b want 1", capture_busy);
        end
        scan_row(2, 1, 148);
        total++;
        if (first_bad >= 0 || line_buf[0] !== FGC) begin
            bad++; $display("FAIL new_row148: x=%0d got %h want %h", first_bad, fb_act, fb_exp);
        end
        scan_row(2, 1, 200);
        total++;
        if (first_bad >= 0 || line_buf[4] !== BGC) begin
            bad++; $display("FAIL new_row200: x=%0d got %h want %h", first_bad, fb_act, fb_exp);
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_display();
        test_delay();
        test_transitions();
        test_abort();
        test_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/step_trace_scheduler.md
Name: step_trace_scheduler

Overview:
- Captures the stepper-motor coil phase signals into a ping-pong sample buffer.
- Renders the captured buffer as four logic-analyser style traces on the HDMI video stream.
- Sits between the video timing generator's de/hsync/vsync outputs and the TMDS encoder.
- Sequences the shared buffer: capture into one bank, display from the other, swap only at frame start.

Parameters:
- DEPTH, 256: samples per capture (power of two).
- XSHIFT, 2: log2 of pixels per sample; trace width is DEPTH<<XSHIFT = 1024 px.
- LANE_TOP, 100: first active row of lane 0.
- LANE_H, 32: rows per lane (must be ≥2).
- LANE_GAP, 16: blank rows between lanes.
- FG, 24'h000000: trace colour.
- BG, 24'heeeeee: background colour.

Ports:
- clock  in  1  pixel clock.
- reset_n  in  1  asynchronous active-low reset.
- capture_en  in  1  enables arming/capture; level sensitive.
- phase  in  4  motor coil signals, already synchronous to clock.
- sample_tick  in  1  one-cycle capture strobe.
- in_de  in  1  video data enable from timing generator.
- in_hsync  in  1  hsync from timing generator.
- in_vsync  in  1  vsync from timing generator.
- video_data  out  24  RGB pixel.
- video_de  out  1  in_de delayed 2 cycles.
- video_hsync  out  1  in_hsync delayed 2 cycles.
- video_vsync  out  1  in_vsync delayed 2 cycles.
- capture_busy  out  1  high in ARMED or CAPTURE.
- frame_valid  out  1  display bank holds a complete capture.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0.
  - FSM = IDLE, cap_bank = 0, disp_bank = 1, wr_addr = 0.
  - Pixel counters x = y = 0; phase_prev = 0.
- Buffer: 2 banks × DEPTH × 4 bits (inferred BSRAM), one write port, one read port.
- Capture FSM:
  - IDLE: go to ARMED when capture_en = 1.
  - ARMED: on a phase[0] rising edge (phase[0] & ~phase_prev[0]), write phase to cap_bank[0], set wr_addr = 1, go to CAPTURE. Any coincident sample_tick is ignored.
  - CAPTURE: each sample_tick writes phase to cap_bank[wr_addr] and increments wr_addr. The write at wr_addr = DEPTH-1 goes to DONE.
  - DONE: on an in_vsync rising edge, swap cap_bank and disp_bank, set frame_valid = 1, set wr_addr = 0, go to ARMED. With no vsync edge, the FSM stays in DONE indefinitely and the display bank is unchanged.
  - capture_en = 0 in any state: next state is IDLE and wr_addr = 0. The partial capture is discarded; disp_bank and frame_valid are unchanged.
  - Swaps occur only at vsync rising edges, so the display bank never changes mid-frame.
- Pixel counters:
  - x increments on each cycle with in_de = 1 and resets to 0 when in_de = 0.
  - y increments on each in_de falling edge and resets to 0 on an in_vsync rising edge (reset takes priority).
- Render pipeline, 2-cycle latency:
  - Stage 1: read sample i = x>>XSHIFT and sample i-1 (i = 0 uses i itself) from disp_bank. Register the lane hit and row offset.
  - Stage 2: register video_data.
- Lane geometry: lane k (0..3) spans rows top_k = LANE_TOP + k*(LANE_H+LANE_GAP) through top_k+LANE_H-1. Let s = sample[i][k] and p = sample[i-1][k].
- Pixel is FG when any of these holds:
  - s = 1 and y = top_k;
  - s = 0 and y = top_k+LANE_H-1;
  - s ≠ p and x[XSHIFT-1:0] = 0 and y lies within the lane.
- Pixel is BG when:
  - x ≥ DEPTH<<XSHIFT;
  - y is outside every lane;
  - frame_valid = 0;
  - the delayed in_de = 0. video_data is forced to 0 when video_de = 0.
- Widths: x and y are 11 bits and saturate at 2047; there is no wrap inside a frame.

Test Plan:
1. Reset mid-CAPTURE (wr_addr = 100): assert reset_n = 0 → all outputs 0 immediately, no clock needed; after release FSM = IDLE and frame_valid = 0.
2. capture_en = 1, phase[0] rises, then 255 sample_ticks with phase = 4'b0001 → DONE after the 255th tick; capture_busy falls; the next vsync rise sets frame_valid = 1 and cap_bank = 1.
3. Displayed frame from scenario 2:
   - Row 100, x = 0..1023 → FG.
   - Row 131 lane 0 → BG.
   - Lane 1 row 179 (148+31) → FG.
   - x = 1024 → BG.
   - Every output equals its input delayed by 2 cycles.
4. Samples alternate 0/1 on phase[2] → FG vertical line at every x multiple of 4 where the sample changes, for rows 196..227 only.
5. capture_en dropped at wr_addr = 50 after one valid frame → FSM = IDLE; the display still shows the old bank; frame_valid stays 1; no swap at subsequent vsyncs.
6. Capture completes mid-frame (y = 300) → no swap until the next in_vsync rise; rows ≥ 300 of the current frame still render the old bank.
